// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin sharing of one spi_master between two byte
// clients, with per-client slave select framing and a busy watchdog.
module spi_bus_arbiter #(
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int GAP      = 2,
    parameter int TIMEOUT  = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant,
    input  logic [7:0] tx_data0,
    input  logic [7:0] tx_data1,
    input  logic [1:0] tx_valid,
    input  logic [1:0] tx_last,
    output logic [1:0] tx_ready,
    output logic [7:0] rx_data,
    output logic [1:0] rx_valid,
    output logic [1:0] ss_n,
    output logic       spi_start,
    output logic [7:0] spi_data_in,
    input  logic       spi_busy,
    input  logic       spi_new_data,
    input  logic [7:0] spi_data_out,
    output logic       timeout_err
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOAD,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_HOLD,
        S_GAP
    } state_t;

    localparam logic [7:0] SETUP_LD = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_LD  = 8'((CS_HOLD > 0) ? CS_HOLD - 1 : 0);
    localparam logic [7:0] GAP_LD   = 8'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [9:0] WD_LIM   = 10'(TIMEOUT - 1);

    state_t     state;
    logic       owner;
    logic       last_owner;
    logic       last_flag;
    logic [7:0] cnt;
    logic [9:0] wd;
    logic       pick;
    logic [1:0] own_bits;
    logic       wd_expired;

    // Contention goes to whoever did not own the bus last.
    assign pick       = (req == 2'b11) ? ~last_owner : req[1];
    assign own_bits   = owner ? 2'b10 : 2'b01;
    assign wd_expired = (wd == WD_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            grant       <= 2'b00;
            tx_ready    <= 2'b00;
            rx_valid    <= 2'b00;
            ss_n        <= 2'b11;
            spi_start   <= 1'b0;
            spi_data_in <= 8'h00;
            rx_data     <= 8'h00;
            timeout_err <= 1'b0;
            owner       <= 1'b0;
            last_owner  <= 1'b1;
            last_flag   <= 1'b0;
            cnt         <= '0;
            wd          <= '0;
        end else begin
            tx_ready  <= 2'b00;
            rx_valid  <= 2'b00;
            spi_start <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        owner <= pick;
                        grant <= pick ? 2'b10 : 2'b01;
                        ss_n  <= pick ? 2'b01 : 2'b10;
                        cnt   <= SETUP_LD;
                        state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) state <= S_LOAD;
                    else cnt <= cnt - 8'd1;
                end
                S_LOAD: begin
                    if (tx_valid[owner]) begin
                        spi_data_in <= owner ? tx_data1 : tx_data0;
                        tx_ready    <= own_bits;
                        last_flag   <= tx_last[owner];
                        spi_start   <= 1'b1;
                        wd          <= '0;
                        state       <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (spi_busy) begin
                        wd    <= '0;
                        state <= S_WAIT_DONE;
                    end else if (wd_expired) begin
                        timeout_err <= 1'b1;
                        ss_n        <= 2'b11;
                        grant       <= 2'b00;
                        last_owner  <= owner;
                        cnt         <= GAP_LD;
                        state       <= S_GAP;
                    end else begin
                        wd <= wd + 10'd1;
                    end
                end
                S_WAIT_DONE: begin
                    // A byte arriving on the abort cycle is dropped.
                    if (spi_new_data && !(spi_busy && wd_expired)) begin
                        rx_data  <= spi_data_out;
                        rx_valid <= own_bits;
                    end
                    if (!spi_busy) begin
                        if (last_flag) begin
                            cnt   <= HOLD_LD;
                            state <= S_HOLD;
                        end else begin
                            state <= S_LOAD;
                        end
                    end else if (wd_expired) begin
                        timeout_err <= 1'b1;
                        ss_n        <= 2'b11;
                        grant       <= 2'b00;
                        last_owner  <= owner;
                        cnt         <= GAP_LD;
                        state       <= S_GAP;
                    end else begin
                        wd <= wd + 10'd1;
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        ss_n       <= 2'b11;
                        grant      <= 2'b00;
                        last_owner <= owner;
                        cnt        <= GAP_LD;
                        state      <= S_GAP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_GAP: begin
                    if (cnt == '0) state <= S_IDLE;
                    else cnt <= cnt - 8'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: directed scenarios with randomized client pacing and
// slave timing, checked against a transaction-level expectation.
module tb_spi_bus_arbiter;
    localparam int CS_SETUP = 4;
    localparam int CS_HOLD  = 4;
    localparam int GAP      = 2;
    localparam int TIMEOUT  = 1023;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req, grant, tx_valid, tx_last, tx_ready, rx_valid, ss_n;
    logic [7:0] tx_data0, tx_data1, rx_data, spi_data_in, spi_data_out;
    logic       spi_start, spi_busy, spi_new_data, timeout_err;

    spi_bus_arbiter #(
        .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .GAP(GAP), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .grant(grant),
        .tx_data0(tx_data0), .tx_data1(tx_data1),
        .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .ss_n(ss_n),
        .spi_start(spi_start), .spi_data_in(spi_data_in),
        .spi_busy(spi_busy), .spi_new_data(spi_new_data),
        .spi_data_out(spi_data_out), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // client byte scripts: {last, data}
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    bit stall_en = 0;

    // slave model knobs and returned bytes
    bit         hang = 0;
    bit         rand_len = 0;
    int         busy_len = 16;
    bit         fixed_en = 1;
    logic [7:0] fixed_resp = 8'h7E;
    logic [7:0] resp_q[$];
    logic [1:0] resp_own[$];

    // expectations
    logic [7:0] exp_dat[$];
    logic [1:0] exp_gnt[$];
    int         exp_ord[$];

    // monitor logs
    int         st_cyc[$];
    logic [7:0] st_dat[$];
    logic [1:0] st_gnt[$];
    int         fall0[$], fall1[$], rise0[$], rise1[$];
    int         gorder[$];
    int         rx_cyc[$];
    logic [7:0] rx_dat[$];
    logic [1:0] rx_bits[$];
    int         bf_cyc[$];
    int         viol = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        st_cyc.delete(); st_dat.delete(); st_gnt.delete();
        fall0.delete(); fall1.delete(); rise0.delete(); rise1.delete();
        gorder.delete(); rx_cyc.delete(); rx_dat.delete(); rx_bits.delete();
        bf_cyc.delete(); resp_q.delete(); resp_own.delete();
        exp_dat.delete(); exp_gnt.delete(); exp_ord.delete();
        viol = 0;
    endtask

    // Service order is strict alternation starting with client 0.
    task automatic gen_rounds(input int rounds);
        for (int r = 0; r < rounds; r++) begin
            for (int c = 0; c < 2; c++) begin
                int nb;
                nb = int'($urandom_range(3, 1));
                exp_ord.push_back(c);
                for (int b = 0; b < nb; b++) begin
                    logic [7:0] d;
                    logic       l;
                    d = 8'($urandom);
                    l = (b == nb - 1);
                    if (c == 0) q0.push_back({l, d});
                    else q1.push_back({l, d});
                    exp_dat.push_back(d);
                    exp_gnt.push_back(c == 0 ? 2'b01 : 2'b10);
                end
            end
        end
    endtask

    task automatic wait_idle(input int maxc, input string tag);
        int n;
        int quiet;
        n = 0;
        quiet = 0;
        while (quiet < GAP + 3 && n < maxc) begin
            tick(1);
            n++;
            if (q0.size() == 0 && q1.size() == 0 && ss_n == 2'b11) quiet++;
            else quiet = 0;
        end
        chk(tag, 32'(quiet >= GAP + 3), 32'd1);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_nstart"}, st_dat.size(), exp_dat.size());
        for (int i = 0; i < exp_dat.size(); i++) begin
            chk({tag, "_byte"}, st_dat[i], exp_dat[i]);
            chk({tag, "_bgnt"}, st_gnt[i], exp_gnt[i]);
        end
        chk({tag, "_ntxn"}, gorder.size(), exp_ord.size());
        for (int i = 0; i < exp_ord.size(); i++)
            chk({tag, "_order"}, gorder[i], exp_ord[i]);
        chk({tag, "_nrx"}, rx_dat.size(), resp_q.size());
        for (int i = 0; i < resp_q.size(); i++) begin
            chk({tag, "_rxdat"}, rx_dat[i], resp_q[i]);
            chk({tag, "_rxbits"}, rx_bits[i], resp_own[i]);
        end
        chk({tag, "_viol"}, viol, 0);
    endtask

    // clients
    initial begin
        req = 2'b00; tx_valid = 2'b00; tx_last = 2'b00;
        tx_data0 = 8'h00; tx_data1 = 8'h00;
        forever begin
            @(posedge clk); #2;
            if (tx_ready[0] && q0.size() != 0) void'(q0.pop_front());
            if (tx_ready[1] && q1.size() != 0) void'(q1.pop_front());
            if (q0.size() != 0) begin
                req[0] = 1'b1;
                tx_valid[0] = !stall_en || ($urandom_range(3) != 0);
                tx_data0 = q0[0][7:0];
                tx_last[0] = q0[0][8];
            end else begin
                req[0] = 1'b0; tx_valid[0] = 1'b0; tx_last[0] = 1'b0;
            end
            if (q1.size() != 0) begin
                req[1] = 1'b1;
                tx_valid[1] = !stall_en || ($urandom_range(3) != 0);
                tx_data1 = q1[0][7:0];
                tx_last[1] = q1[0][8];
            end else begin
                req[1] = 1'b0; tx_valid[1] = 1'b0; tx_last[1] = 1'b0;
            end
        end
    end

    // spi_master stand-in
    initial begin
        int  left;
        bit  was_hang;
        spi_busy = 1'b0; spi_new_data = 1'b0; spi_data_out = 8'h00;
        left = 0; was_hang = 0;
        forever begin
            @(posedge clk); #2;
            spi_new_data = 1'b0;
            if (rst) begin
                spi_busy = 1'b0;
                was_hang = 0;
            end else if (spi_busy) begin
                if (hang) begin
                    was_hang = 1;
                end else if (was_hang) begin
                    spi_busy = 1'b0;
                    was_hang = 0;
                end else begin
                    left--;
                    if (left <= 0) begin
                        spi_busy = 1'b0;
                        spi_new_data = 1'b1;
                        spi_data_out = fixed_en ? fixed_resp : 8'($urandom);
                        resp_q.push_back(spi_data_out);
                        resp_own.push_back(~ss_n);
                    end
                end
            end else if (spi_start) begin
                spi_busy = 1'b1;
                left = rand_len ? int'($urandom_range(20, 3)) : busy_len;
            end
        end
    end

    // monitor
    initial begin
        logic [1:0] pss;
        logic [1:0] pgnt;
        logic       pbusy;
        pss = 2'b11; pgnt = 2'b00; pbusy = 1'b0;
        forever begin
            @(negedge clk);
            if (spi_start === 1'b1) begin
                st_cyc.push_back(cyc);
                st_dat.push_back(spi_data_in);
                st_gnt.push_back(grant);
            end
            if (pss[0] && !ss_n[0]) fall0.push_back(cyc);
            if (!pss[0] && ss_n[0]) rise0.push_back(cyc);
            if (pss[1] && !ss_n[1]) fall1.push_back(cyc);
            if (!pss[1] && ss_n[1]) rise1.push_back(cyc);
            if (pgnt == 2'b00 && grant != 2'b00) gorder.push_back(grant[1] ? 1 : 0);
            if (rx_valid != 2'b00) begin
                rx_cyc.push_back(cyc);
                rx_dat.push_back(rx_data);
                rx_bits.push_back(rx_valid);
            end
            if (pbusy && !spi_busy) bf_cyc.push_back(cyc);
            if (grant == 2'b11 || ss_n != ~grant || (spi_start && ss_n == 2'b11))
                viol++;
            pss = ss_n; pgnt = grant; pbusy = spi_busy;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        int s;
        int t_rise;
        rst = 1'b1;
        tick(3);
        chk("rst_grant", grant, 2'b00);
        chk("rst_ss_n", ss_n, 2'b11);
        chk("rst_tx_ready", tx_ready, 2'b00);
        chk("rst_rx_valid", rx_valid, 2'b00);
        chk("rst_start", spi_start, 1'b0);
        chk("rst_data_in", spi_data_in, 8'h00);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_tmo", timeout_err, 1'b0);
        rst = 1'b0;
        tick(2);

        // single three-byte transaction on client 0
        clear_logs();
        q0.push_back({1'b0, 8'hA5});
        q0.push_back({1'b0, 8'h3C});
        q0.push_back({1'b1, 8'hF0});
        exp_dat = '{8'hA5, 8'h3C, 8'hF0};
        exp_gnt = '{2'b01, 2'b01, 2'b01};
        exp_ord = '{0};
        wait_idle(2000, "t1_done");
        check_stream("t1");
        chk("t1_nfall0", fall0.size(), 1);
        chk("t1_setup", st_cyc[0] - fall0[0], CS_SETUP + 1);
        chk("t1_nbf", bf_cyc.size(), 3);
        chk("t1_hold", rise0[0] - bf_cyc[2], CS_HOLD + 1);
        chk("t1_ss1", fall1.size(), 0);
        chk("t1_rxval", rx_dat[2], 8'h7E);
        chk("t1_rx_lat", rx_cyc[2] - bf_cyc[2], 1);

        // contention from reset
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        clear_logs();
        stall_en = 1; rand_len = 1; fixed_en = 0;
        gen_rounds(1);
        wait_idle(2000, "t2_done");
        check_stream("t2");
        chk("t2_gap", fall1[0] - rise0[0], GAP + 1);

        // fairness over four transactions per client
        clear_logs();
        gen_rounds(4);
        wait_idle(8000, "t3_done");
        check_stream("t3");

        // watchdog on a hung slave
        clear_logs();
        hang = 1;
        q0.push_back({1'b1, 8'h55});
        n = 0;
        while (st_cyc.size() == 0 && n < 200) begin
            tick(1);
            n++;
        end
        chk("t4_start", st_cyc.size(), 1);
        s = (st_cyc.size() != 0) ? st_cyc[0] : cyc;
        while (cyc < s + TIMEOUT - 4) tick(1);
        chk("t4_early", timeout_err, 1'b0);
        chk("t4_ss_low", ss_n, 2'b10);
        n = 0;
        while (timeout_err !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        t_rise = cyc;
        chk("t4_tmo", timeout_err, 1'b1);
        chk("t4_when", 32'(t_rise >= s + TIMEOUT - 3 && t_rise <= s + TIMEOUT + 4), 32'd1);
        chk("t4_ss", ss_n, 2'b11);
        chk("t4_grant", grant, 2'b00);
        chk("t4_norx", rx_dat.size(), 0);
        hang = 0;
        wait_idle(200, "t4_idle");
        clear_logs();
        q0.push_back({1'b1, 8'h99});
        exp_dat = '{8'h99};
        exp_gnt = '{2'b01};
        exp_ord = '{0};
        wait_idle(2000, "t4_after");
        check_stream("t4");
        chk("t4_sticky", timeout_err, 1'b1);

        // reset during the second byte
        clear_logs();
        stall_en = 0; rand_len = 0; busy_len = 16;
        q0.push_back({1'b0, 8'h11});
        q0.push_back({1'b0, 8'h22});
        q0.push_back({1'b1, 8'h33});
        n = 0;
        while (st_cyc.size() < 2 && n < 400) begin
            tick(1);
            n++;
        end
        chk("t5_second", st_cyc.size(), 2);
        tick(4);
        chk("t5_busy", spi_busy, 1'b1);
        rst = 1'b1;
        tick(1);
        chk("t5_ss", ss_n, 2'b11);
        chk("t5_grant", grant, 2'b00);
        chk("t5_start", spi_start, 1'b0);
        chk("t5_tmo", timeout_err, 1'b0);
        q0.delete();
        q1.delete();
        tick(1);
        rst = 1'b0;
        tick(1);
        clear_logs();
        rand_len = 1;
        gen_rounds(1);
        wait_idle(2000, "t5_done");
        check_stream("t5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
